// File: rtl/perceptron_bp_pkg.sv
// Shared types and constants for the perceptron branch predictor.
// Holds the default global-history width and the checkpoint entry layout.
package perceptron_bp_pkg;

    localparam int GHR_HIST_LEN = 32;

    typedef struct packed {
        logic [GHR_HIST_LEN-1:0] hist;
        logic                    pred_taken;
    } ghr_ckpt_t;

endpackage

// File: rtl/ghr_checkpoint_fifo.sv
// In-order queue of speculative global-history checkpoints; emits the corrected
// history as a one-cycle restore pulse on a mispredict and clears younger entries.
module ghr_checkpoint_fifo
    import perceptron_bp_pkg::*;
#(
    parameter int HIST_LEN = GHR_HIST_LEN,
    parameter int DEPTH    = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_valid,
    output logic                       push_ready,
    input  logic [HIST_LEN-1:0]        push_hist,
    input  logic                       push_pred_taken,
    input  logic                       resolve_valid,
    input  logic                       resolve_taken,
    input  logic                       flush,
    output logic                       restore_valid,
    output logic [HIST_LEN-1:0]        restore_hist,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Width follows HIST_LEN, so the entry layout is declared locally.
    typedef struct packed {
        logic [HIST_LEN-1:0] hist;
        logic                pred_taken;
    } ckpt_t;

    ckpt_t               mem_q [DEPTH];
    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                restore_valid_q, restore_valid_d;
    logic [HIST_LEN-1:0] restore_hist_q, restore_hist_d;
    logic                err_q, err_d;

    logic                queue_empty;
    logic                push_fire;
    logic                resolve_fire;
    logic                mispredict;
    logic                push_we;
    ckpt_t               head_entry;
    logic [HIST_LEN-1:0] corrected_hist;

    assign queue_empty  = (count_q == '0);
    assign push_ready   = (count_q < CNT_W'(DEPTH));
    assign push_fire    = push_valid && push_ready;
    assign resolve_fire = resolve_valid && !queue_empty;
    assign head_entry   = mem_q[head_q];
    assign mispredict   = resolve_fire && (resolve_taken != head_entry.pred_taken);
    // Pending push is discarded on flush or when an older branch mispredicts.
    assign push_we      = push_fire && !flush && !mispredict;

    // Shift the actual outcome into the pre-branch history snapshot.
    assign corrected_hist = (head_entry.hist << 1) | HIST_LEN'(resolve_taken);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        head_d          = head_q;
        tail_d          = tail_q;
        count_d         = count_q;
        restore_valid_d = mispredict;
        restore_hist_d  = mispredict ? corrected_hist : restore_hist_q;
        err_d           = err_q | (resolve_valid && queue_empty);

        if (flush || mispredict) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_we) begin
                tail_d = tail_q + PTR_W'(1);
            end
            if (resolve_fire) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_we) - CNT_W'(resolve_fire);
        end
    end

    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_q          <= '0;
            tail_q          <= '0;
            count_q         <= '0;
            restore_valid_q <= 1'b0;
            restore_hist_q  <= '0;
            err_q           <= 1'b0;
        end else begin
            head_q          <= head_d;
            tail_q          <= tail_d;
            count_q         <= count_d;
            restore_valid_q <= restore_valid_d;
            restore_hist_q  <= restore_hist_d;
            err_q           <= err_d;
        end
    end

    // NOTE: entry storage has no reset; count gates every read, so stale data is never observed.
    always_ff @(posedge clk) begin
        if (push_we) begin
            mem_q[tail_q] <= '{hist: push_hist, pred_taken: push_pred_taken};
        end
    end

    assign restore_valid = restore_valid_q;
    assign restore_hist  = restore_hist_q;
    assign count         = count_q;
    assign err           = err_q;

endmodule

// File: tb/tb_ghr_checkpoint_fifo.sv
// Randomized and directed bench for ghr_checkpoint_fifo against a queue-based model.
module tb_ghr_checkpoint_fifo;
    import perceptron_bp_pkg::*;

    localparam int HL    = GHR_HIST_LEN;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          push_valid, push_ready, push_pred_taken;
    logic [HL-1:0] push_hist;
    logic          resolve_valid, resolve_taken, flush;
    logic          restore_valid;
    logic [HL-1:0] restore_hist;
    logic [$clog2(DEPTH):0] count;
    logic          err;

    ghr_checkpoint_fifo #(.HIST_LEN(HL), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .push_valid(push_valid), .push_ready(push_ready),
        .push_hist(push_hist), .push_pred_taken(push_pred_taken),
        .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
        .flush(flush), .restore_valid(restore_valid), .restore_hist(restore_hist),
        .count(count), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queue of checkpoints plus the output registers.
    ghr_ckpt_t     q[$];
    logic          m_rv;
    logic [HL-1:0] m_rh;
    logic          m_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_rv  = 1'b0;
        m_rh  = '0;
        m_err = 1'b0;
    endtask

    task automatic model_step(input logic pv, input logic [HL-1:0] ph, input logic pp,
                              input logic rv, input logic rt, input logic fl);
        bit ready = q.size() < DEPTH;
        bit mis   = 1'b0;
        m_rv = 1'b0;
        if (rv && q.size() == 0) begin
            m_err = 1'b1;
        end else if (rv && q[0].pred_taken != rt) begin
            mis  = 1'b1;
            m_rv = 1'b1;
            m_rh = HL'((q[0].hist * 2) + rt);
        end
        if (fl || mis) begin
            q.delete();
        end else begin
            if (rv && q.size() > 0) void'(q.pop_front());
            if (pv && ready) q.push_back('{hist: ph, pred_taken: pp});
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".count"}, 64'(count), 64'(q.size()));
        check({tag, ".ready"}, 64'(push_ready), 64'(q.size() < DEPTH));
        check({tag, ".rv"}, 64'(restore_valid), 64'(m_rv));
        check({tag, ".rh"}, 64'(restore_hist), 64'(m_rh));
        check({tag, ".err"}, 64'(err), 64'(m_err));
    endtask

    // One clock: drive inputs, advance the model at the edge, compare 1 ns later.
    task automatic step(input string tag, input logic pv, input logic [HL-1:0] ph, input logic pp,
                        input logic rv, input logic rt, input logic fl);
        push_valid = pv; push_hist = ph; push_pred_taken = pp;
        resolve_valid = rv; resolve_taken = rt; flush = fl;
        @(posedge clk);
        model_step(pv, ph, pp, rv, rt, fl);
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic          rt;
        logic [HL-1:0] rh;

        reset = 1'b1;
        push_valid = 0; push_hist = '0; push_pred_taken = 0;
        resolve_valid = 0; resolve_taken = 0; flush = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 compare_all("reset");
        @(negedge clk) reset = 1'b0;
        idle("post_reset");

        // In-order correct resolves.
        step("push1", 1, 32'h1, 1, 0, 0, 0);
        step("push2", 1, 32'h2, 0, 0, 0, 0);
        step("push3", 1, 32'h3, 1, 0, 0, 0);
        step("res1", 0, '0, 0, 1, 1, 0);
        step("res2", 0, '0, 0, 1, 0, 0);
        step("res3", 0, '0, 0, 1, 1, 0);
        idle("inorder_end");

        // Mispredict on the oldest of three.
        step("mp_push0", 1, 32'hA5A5A5A5, 1, 0, 0, 0);
        step("mp_push1", 1, 32'h11111111, 0, 0, 0, 0);
        step("mp_push2", 1, 32'h22222222, 1, 0, 0, 0);
        step("mp_res", 0, '0, 0, 1, 0, 0);
        check("mp_rh_const", 64'(restore_hist), 64'h4B4B4B4A);
        idle("mp_pulse_end");

        // Fill, overflow attempt, resolve+push while full, drain across the wrap.
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1, HL'(32'h100 + i), 1'(i % 3 == 0), 0, 0, 0);
        check("full_ready_const", 64'(push_ready), 64'h0);
        step("overflow", 1, 32'hDEAD, 1, 0, 0, 0);
        step("full_res_push", 1, 32'h200, 0, 1, q[0].pred_taken, 0);
        check("full_count_const", 64'(count), 64'(DEPTH - 1));
        step("refill", 1, 32'h201, 1, 1, q[0].pred_taken, 0);
        check("refill_count_const", 64'(count), 64'(DEPTH - 1));
        step("topup", 1, 32'h202, 0, 0, 0, 0);
        while (q.size() > 1) step("drain", 0, '0, 0, 1, q[0].pred_taken, 0);
        rh = HL'((q[0].hist * 2) + !q[0].pred_taken);
        step("drain_last_mp", 0, '0, 0, 1, !q[0].pred_taken, 0);
        check("wrap_tail_hist", 64'(restore_hist), 64'(rh));

        // Resolve on empty raises a sticky error.
        step("empty_res", 0, '0, 0, 1, 1, 0);
        idle("err_sticky");
        step("push_after_err", 1, 32'h5, 0, 0, 0, 0);
        step("pop_after_err", 0, '0, 0, 1, 0, 0);

        // Flush with 5 entries plus a simultaneous push.
        for (int i = 0; i < 5; i++) step("pre_flush", 1, HL'(i), 1'(i & 1), 0, 0, 0);
        step("flush_push", 1, 32'h77, 1, 0, 0, 1);
        check("flush_count_const", 64'(count), 64'h0);
        idle("after_flush");

        // Randomized traffic, mostly correct predictions.
        for (int i = 0; i < 600; i++) begin
            logic pv, rv, fl;
            pv = ($urandom_range(0, 99) < 60);
            rv = ($urandom_range(0, 99) < 40);
            fl = ($urandom_range(0, 99) < 3);
            if (q.size() > 0 && $urandom_range(0, 9) < 8) rt = q[0].pred_taken;
            else rt = 1'($urandom);
            step("rand", pv, HL'($urandom), 1'($urandom), rv, rt, fl);
        end

        // Async reset between edges, with a mispredict pending.
        step("ar_flush", 0, '0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("ar_fill", 1, HL'(32'h900 + i), 1, 0, 0, 0);
        push_valid = 0; resolve_valid = 1; resolve_taken = 0;
        #2 reset = 1'b1;
        model_reset();
        #1 compare_all("ar_immediate");
        resolve_valid = 0;
        @(posedge clk);
        #1 compare_all("ar_held");
        @(negedge clk) reset = 1'b0;
        idle("ar_released");
        idle("ar_released2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Guard against a hung simulation.
    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
